mem_burst_ctrl: RTL

// - Parametrised memory slave on the multiplexed main bus. Replaces the fixed 16-bit/4-beat page slave.
// - Decodes one page and runs a BURST_LEN-beat read or write burst against the memory array port.
// - Address and data widths are configurable. The burst length is configurable.
// - Adds a burst-done pulse and optional wrapping bursts.
// - Sits between main_bus_if (slave side) and memArray_if (MemIF side).

---
 rtl/mem_burst_pkg.sv | 25 ++
 rtl/mem_burst_addr_gen.sv | 68 ++++++
 rtl/mem_burst_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_burst_pkg.sv
// Shared types and helpers for the paged burst memory slave.
package mem_burst_pkg;

  // Controller states: waiting for an address cycle, or running beats.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Type used for the burst length parameter.
  typedef int unsigned burst_len_t;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int unsigned clog2_min1(input burst_len_t n);
    int unsigned w;
    w = $clog2(n);
    return (w == 0) ? 1 : w;
  endfunction

  // True when n is a non-zero power of two.
  function automatic bit is_pow2(input burst_len_t n);
    return (n != 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/mem_burst_addr_gen.sv
// Burst address register: loads on the address cycle and steps the in-page
// offset once per beat. The page bits never change during a burst.
// Define MEM_BURST_WRAP_EN to wrap within a BURST_LEN-aligned block instead
// of incrementing linearly through the page.
module mem_burst_addr_gen
  import mem_burst_pkg::*;
#(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned PAGE_W    = 4,
  parameter burst_len_t  BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              resetH,
  input  logic              load_i,
  input  logic              incr_i,
  input  logic [DATA_W-1:0] addr_i,
  output logic [DATA_W-1:0] addr_o
);

  localparam int unsigned OFF_W = DATA_W - PAGE_W;

  if (BURST_LEN < 1 || BURST_LEN > (1 << OFF_W)) begin : g_len_chk
    $error("mem_burst_addr_gen: BURST_LEN %0d outside 1..2**%0d", BURST_LEN, OFF_W);
  end

  logic [DATA_W-1:0] addr_q, addr_d;
  logic [OFF_W-1:0]  off_q;
  logic [OFF_W-1:0]  off_next;

  assign off_q = addr_q[OFF_W-1:0];

`ifdef MEM_BURST_WRAP_EN
  if (!is_pow2(BURST_LEN)) begin : g_pow2_chk
    $error("mem_burst_addr_gen: wrapping bursts need a power-of-2 BURST_LEN, got %0d", BURST_LEN);
  end

  // Low bits covered by the mask wrap; the block-select bits above them hold.
  localparam logic [OFF_W-1:0] WRAP_MASK = OFF_W'(BURST_LEN - 1);
  assign off_next = (off_q & ~WRAP_MASK) | ((off_q + OFF_W'(1)) & WRAP_MASK);
`else
  // Natural OFF_W-bit overflow keeps the burst inside its page.
  assign off_next = off_q + OFF_W'(1);
`endif

  // Next address: load on acceptance, step the offset on each beat.
  always_comb begin
    // NOTE: assign a default first so every path drives addr_d and no latch is inferred.
    addr_d = addr_q;
    if (load_i) begin
      addr_d = addr_i;
    end else if (incr_i) begin
      addr_d = {addr_q[DATA_W-1 -: PAGE_W], off_next};
    end
  end

  // Address register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
    if (resetH) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/mem_burst_ctrl.sv
// Paged burst memory slave on the multiplexed main bus. Decodes one page and
// runs a BURST_LEN-beat read or write burst against the memory array port.
// Optional build macro: MEM_BURST_WRAP_EN (wrapping bursts, see address generator).
module mem_burst_ctrl
  import mem_burst_pkg::*;
#(
  parameter int unsigned       DATA_W    = 16,
  parameter int unsigned       PAGE_W    = 4,
  parameter logic [PAGE_W-1:0] PAGE      = PAGE_W'(4'h2),
  parameter burst_len_t        BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              resetH,
  input  logic              AddrValid,
  input  logic              rw,
  input  logic [DATA_W-1:0] AddrDataIn,
  output logic [DATA_W-1:0] AddrDataOut,
  output logic              AddrDataOE,
  output logic [DATA_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemDataIn,
  input  logic [DATA_W-1:0] MemDataOut,
  output logic              MemRdEn,
  output logic              MemWrEn,
  output logic              BurstDone
);

  localparam int unsigned      BEAT_W    = clog2_min1(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t            state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic              rw_q, rw_d;
  logic              load;
  logic              incr;
  logic              page_hit;
  logic [DATA_W-1:0] addr_cur;

  assign page_hit = (AddrDataIn[DATA_W-1 -: PAGE_W] == PAGE);

  mem_burst_addr_gen #(
    .DATA_W    (DATA_W),
    .PAGE_W    (PAGE_W),
    .BURST_LEN (BURST_LEN)
  ) u_addr_gen (
    .clk    (clk),
    .resetH (resetH),
    .load_i (load),
    .incr_i (incr),
    .addr_i (AddrDataIn),
    .addr_o (addr_cur)
  );

  // State, beat counter and direction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (resetH) begin
      state_q <= IDLE;
      beat_q  <= '0;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      rw_q    <= rw_d;
    end
  end

  // Next-state logic and registered-state output decode.
  always_comb begin
    state_d     = IDLE;
    beat_d      = '0;
    rw_d        = rw_q;
    load        = 1'b0;
    incr        = 1'b0;
    AddrDataOut = '0;
    AddrDataOE  = 1'b0;
    MemAddr     = '0;
    MemDataIn   = '0;
    MemRdEn     = 1'b0;
    MemWrEn     = 1'b0;
    BurstDone   = 1'b0;

    case (state_q)
      IDLE: begin
        // Address cycles are only looked at here; during a burst they are ignored.
        if (AddrValid && page_hit) begin
          state_d = BURST;
          load    = 1'b1;
          rw_d    = rw;
        end
      end

      BURST: begin
        incr    = 1'b1;
        MemAddr = addr_cur;
        if (rw_q) begin
          MemRdEn     = 1'b1;
          AddrDataOE  = 1'b1;
          AddrDataOut = MemDataOut;
        end else begin
          MemWrEn   = 1'b1;
          MemDataIn = AddrDataIn;
        end
        BurstDone = (beat_q == LAST_BEAT);
        if (beat_q != LAST_BEAT) begin
          state_d = BURST;
          beat_d  = beat_q + BEAT_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
